hidden_layer_seq: RTL
=====================

// Module: hidden_layer_seq
// PURPOSE
//  Sequential hidden layer directly upstream of the output neuron. Computes 8 hidden
//  activations x0..x7 (10-bit) from N_IN unsigned input features and 1.7 weights using one
//  shared multiplier. Weights come from an external weight store via a combinational read port.
//  Results are held stable and announced with a one-cycle done_o, which drives the neuron's en_i.
// PARAMETERS
//  N_IN    4   number of input features (>=1)
//  IN_W    4   bits per input feature, unsigned
//  W_W     8   bits per weight, unsigned 1.7 fixed point
//  ACC_W   16  accumulator width; must hold N_IN*(2^IN_W-1)*(2^W_W-1)
//  SHIFT   3   right shift applied to the accumulator before saturation
//  ADDR_W  5   weight address width; must satisfy 2^ADDR_W >= 8*N_IN
// PORTS
//  clk_i      in   1          clock, rising edge
//  rst_i      in   1          reset, synchronous, active-high
//  start_i    in   1          start request; sampled only in IDLE
//  feat_i     in   N_IN*IN_W  features; feature k = feat_i[k*IN_W +: IN_W]
//  w_addr_o   out  ADDR_W     weight address = j*N_IN + k (neuron j, feature k)
//  w_data_i   in   W_W        weight at w_addr_o, same cycle (combinational read)
//  busy_o     out  1          high in any state other than IDLE
//  done_o     out  1          one-cycle pulse; x0..x7 valid and stable
//  x0_o..x7_o out  10 each    hidden activations, registered
// BEHAVIOUR
//  - Reset (rst_i=1 at an edge): state<=IDLE; j, k and acc<=0; x0..x7<=0.
//    done_o and busy_o are 0 in the next cycle. w_addr_o is 0 in IDLE.
//  - A reset mid-operation aborts the run. No partial results survive.
//  - States: IDLE, MAC, STORE, DONE.
//  - IDLE: if start_i=1, latch feat_i into an internal register, set j=0, k=0, acc=0, go to MAC.
//    feat_i is ignored after the latch edge.
//  - MAC: each edge, acc += feat[k]*w_data_i. Operands are zero-extended and unsigned.
//    Increment k. When k==N_IN-1, go to STORE instead and reset k to 0.
//  - STORE: x_j <= (acc>>SHIFT) > 1023 ? 1023 : acc>>SHIFT. Clear acc.
//    If j==7, go to DONE; otherwise j++ and return to MAC.
//  - DONE: done_o=1 combinationally for exactly this cycle; next state is IDLE.
//  - Latency: start sampled at edge E0; done_o is high in the cycle after edge E0+8*(N_IN+1).
//    For defaults this is 40 edges, so done_o is high during cycle 41. Next start can be
//    accepted at the edge ending DONE+1, i.e. in IDLE.
//  - x_j changes only at its own STORE edge. Otherwise all x hold their value, including across
//    IDLE and new runs until overwritten. Downstream must sample only on done_o.
//  - start_i while busy_o=1 is ignored; it is not queued. start_i held high continuously
//    restarts the layer immediately after each DONE.
//  - Arithmetic has no overflow inside acc, given the ACC_W rule. Saturation to 10 bits is the
//    only lossy step. There is no sign handling.
// TESTING
//  1 Reset: assert rst_i 2 cycles mid-run at cycle 10 -> next cycle busy_o=0, done_o=0,
//    x0..x7=0, and no done_o ever follows.
//  2 Address ramp: w_data_i=w_addr_o, feat=(1,2,3,4) for k=0..3, start ->
//    x_j=(40j+20)>>3: x0=2, x1=7, x2=12, x3=17, x4=22, x5=27, x6=32, x7=37.
//    done_o is high only in cycle 41.
//  3 Unity weights: all w=0x80, all feat=15 -> every x=960 (7680>>3). No saturation.
//  4 Saturation: all w=0xFF, all feat=15 -> acc=15300, and 15300>>3=1912 gives every x=1023.
//  5 Zero: feat=0 with any weights -> all x=0. done_o still pulses at cycle 41.
//  6 Busy start: pulse start_i at cycles 5 and 20 of a run -> a single done_o.
//    Results match the first latched feat_i. feat_i changed after E0 has no effect.

Source files
------------

// File: rtl/hidden_layer_seq.sv
// hidden_layer_seq
//   Sequential hidden layer feeding the output neuron. Eight activations x0..x7
//   are computed one after another from N_IN unsigned features and unsigned
//   1.7 weights, using one shared multiplier. Weights are read combinationally
//   from an external store. Each result is the accumulated sum shifted right by
//   SHIFT and saturated to 10 bits.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for start_i; features latched on the accepting edge
//   MAC   | one multiply-accumulate per edge for neuron j, feature k
//   STORE | write the saturated result to x_j, clear acc, next neuron
//   DONE  | done_o high for this single cycle; back to IDLE
//
// Ports
//   clk_i, rst_i      clock (rising edge), synchronous active-high reset
//   start_i           start request, sampled only in IDLE
//   feat_i            packed features, feature k = feat_i[k*IN_W +: IN_W]
//   w_addr_o          weight address j*N_IN + k (0 outside MAC)
//   w_data_i          weight at w_addr_o, same cycle
//   busy_o            high in every state except IDLE
//   done_o            one-cycle pulse, x0..x7 valid and stable
//   x0_o..x7_o        registered hidden activations
module hidden_layer_seq #(
  parameter int N_IN   = 4,
  parameter int IN_W   = 4,
  parameter int W_W    = 8,
  parameter int ACC_W  = 16,
  parameter int SHIFT  = 3,
  parameter int ADDR_W = 5
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [N_IN*IN_W-1:0]   feat_i,
  output logic [ADDR_W-1:0]      w_addr_o,
  input  logic [W_W-1:0]         w_data_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [9:0]             x0_o,
  output logic [9:0]             x1_o,
  output logic [9:0]             x2_o,
  output logic [9:0]             x3_o,
  output logic [9:0]             x4_o,
  output logic [9:0]             x5_o,
  output logic [9:0]             x6_o,
  output logic [9:0]             x7_o
);

  localparam int K_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int P_W = IN_W + W_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MAC   = 2'd1,
    S_STORE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  logic [2:0]            r_j;
  logic [K_W-1:0]        r_k;
  logic [ACC_W-1:0]      r_acc;
  logic [N_IN*IN_W-1:0]  r_feat;
  logic [9:0]            r_x [8];

  logic [IN_W-1:0]       w_feat_k;
  logic [P_W-1:0]        w_prod;
  logic [ACC_W-1:0]      w_sum;
  logic [ACC_W-1:0]      w_shifted;
  logic [9:0]            w_sat;
  logic                  w_k_last;

  assign w_feat_k  = r_feat[r_k*IN_W +: IN_W];
  // Both operands zero-extended to the full product width.
  assign w_prod    = {{W_W{1'b0}}, w_feat_k} * {{IN_W{1'b0}}, w_data_i};
  assign w_sum     = r_acc + ACC_W'(w_prod);
  assign w_shifted = r_acc >> SHIFT;
  assign w_sat     = (w_shifted > ACC_W'(1023)) ? 10'd1023 : w_shifted[9:0];
  assign w_k_last  = (r_k == K_W'(N_IN - 1));

  assign w_addr_o = (r_state == S_MAC)
                    ? (ADDR_W'(r_j) * ADDR_W'(N_IN) + ADDR_W'(r_k))
                    : '0;
  assign busy_o   = (r_state != S_IDLE);
  assign done_o   = (r_state == S_DONE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_j     <= '0;
      r_k     <= '0;
      r_acc   <= '0;
      r_feat  <= '0;
      for (int i = 0; i < 8; i++) r_x[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_feat  <= feat_i;
            r_j     <= '0;
            r_k     <= '0;
            r_acc   <= '0;
            r_state <= S_MAC;
          end
        end
        S_MAC: begin
          r_acc <= w_sum;
          if (w_k_last) begin
            r_k     <= '0;
            r_state <= S_STORE;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        S_STORE: begin
          r_x[r_j] <= w_sat;
          r_acc    <= '0;
          if (r_j == 3'd7) begin
            r_state <= S_DONE;
          end else begin
            r_j     <= r_j + 1'b1;
            r_state <= S_MAC;
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign x0_o = r_x[0];
  assign x1_o = r_x[1];
  assign x2_o = r_x[2];
  assign x3_o = r_x[3];
  assign x4_o = r_x[4];
  assign x5_o = r_x[5];
  assign x6_o = r_x[6];
  assign x7_o = r_x[7];

endmodule
